// File: rtl/fft_r22sdf_pkg.sv
// Shared definitions for the R2^2 SDF butterfly stages.
package fft_r22sdf_pkg;

    // Rotation applied to quarter-3 samples in the BF-II stage.
    typedef enum logic {
        ROT_FWD = 1'b0,   // multiply by -j
        ROT_INV = 1'b1    // multiply by +j
    } rot_mode_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Divide by two with round-half-up: (v + 1) >>> 1.
    function automatic logic signed [63:0] round_shr1(input logic signed [63:0] value);
        return (value + 64'sd1) >>> 1;
    endfunction

endpackage

// File: rtl/fft_sdf_delay_line.sv
// Enable-gated feedback shift register for SDF butterfly stages.
// No reset so the storage can map onto SRLs or block RAM.
module fft_sdf_delay_line #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned LEN   = 256
) (
    input  logic             clk,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem_q [LEN];
    logic [WIDTH-1:0] mem_d [LEN];

    // Next contents: new entry at the head, everything else moves one place.
    always_comb begin
        mem_d[0] = d;
        for (int unsigned i = 1; i < LEN; i++) begin
            mem_d[i] = mem_q[i-1];
        end
    end

    // Shift only on accepted samples.
    always_ff @(posedge clk) begin
        if (ce) begin
            mem_q <= mem_d;
        end
    end

    assign q = mem_q[LEN-1];

endmodule

// File: rtl/fft_r22sdf_bfii_stage.sv
// Radix-2^2 SDF butterfly-II stage, self-sequenced from an internal sample
// counter. Output frame index 0 is produced by input index L.
module fft_r22sdf_bfii_stage
    import fft_r22sdf_pkg::*;
#(
    parameter  int DATA_WIDTH    = 25,
    parameter  int SHIFT_REG_LEN = 256,
    parameter  int SCALE         = 0,
    localparam int OUT_WIDTH     = DATA_WIDTH + 1 - SCALE
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic                  sync_i,
    input  logic                  inverse_i,
    input  logic [DATA_WIDTH-1:0] x_re_i,
    input  logic [DATA_WIDTH-1:0] x_im_i,
    output logic                  valid_o,
    output logic                  sync_o,
    output logic [OUT_WIDTH-1:0]  z_re_o,
    output logic [OUT_WIDTH-1:0]  z_im_o
);

    localparam int unsigned LOG2L = clog2(SHIFT_REG_LEN);
    localparam int unsigned CW    = LOG2L + 2;
    localparam int unsigned W     = DATA_WIDTH + 1;

    logic [CW-1:0]        cnt_q, cnt_d, idx;
    logic [LOG2L:0]       prime_q, prime_d;
    logic                 primed, sel, rot;
    logic signed [W-1:0]  x_re, x_im, op_re, op_im;
    logic signed [W-1:0]  d_re, d_im, v_re, v_im, w_re, w_im;
    logic [2*W-1:0]       dl_d, dl_q;
    logic                 valid_q, valid_d, sync_q, sync_d;
    logic [OUT_WIDTH-1:0] z_re_q, z_re_d, z_im_q, z_im_d;

    // Sample index, butterfly selects and priming count.
    always_comb begin
        idx     = sync_i ? '0 : cnt_q;
        sel     = idx[LOG2L];
        rot     = sel & idx[CW-1];
        primed  = (prime_q == (LOG2L+1)'(SHIFT_REG_LEN));
        cnt_d   = cnt_q;
        prime_d = prime_q;
        if (valid_i) begin
            cnt_d = sync_i ? CW'(1) : cnt_q + CW'(1);
            if (!primed) begin
                prime_d = prime_q + (LOG2L+1)'(1);
            end
        end
    end

    // Butterfly: pass-through/store in sel=0, add/subtract in sel=1, with the
    // quarter-3 operand rotated by -j or +j.
    always_comb begin
        x_re  = {x_re_i[DATA_WIDTH-1], x_re_i};
        x_im  = {x_im_i[DATA_WIDTH-1], x_im_i};
        {d_re, d_im} = dl_q;
        op_re = x_re;
        op_im = x_im;
        if (rot) begin
            if (rot_mode_e'(inverse_i) == ROT_INV) begin
                op_re = -x_im;
                op_im = x_re;
            end else begin
                op_re = x_im;
                op_im = -x_re;
            end
        end
        if (sel) begin
            v_re = d_re + op_re;
            v_im = d_im + op_im;
            w_re = d_re - op_re;
            w_im = d_im - op_im;
        end else begin
            v_re = d_re;
            v_im = d_im;
            w_re = x_re;
            w_im = x_im;
        end
        dl_d = {w_re, w_im};
    end

    fft_sdf_delay_line #(
        .WIDTH (2 * W),
        .LEN   (SHIFT_REG_LEN)
    ) u_delay (
        .clk (clk_i),
        .ce  (valid_i),
        .d   (dl_d),
        .q   (dl_q)
    );

    // Output register inputs; z holds when no primed sample is accepted.
    always_comb begin
        valid_d = valid_i & primed;
        sync_d  = valid_i & primed & (idx == CW'(SHIFT_REG_LEN));
        z_re_d  = z_re_q;
        z_im_d  = z_im_q;
        if (valid_i && primed) begin
            if (SCALE != 0) begin
                z_re_d = OUT_WIDTH'(round_shr1(64'(v_re)));
                z_im_d = OUT_WIDTH'(round_shr1(64'(v_im)));
            end else begin
                z_re_d = v_re[OUT_WIDTH-1:0];
                z_im_d = v_im[OUT_WIDTH-1:0];
            end
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            prime_q <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            z_re_q  <= '0;
            z_im_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            prime_q <= prime_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
            z_re_q  <= z_re_d;
            z_im_q  <= z_im_d;
        end
    end

    assign valid_o = valid_q;
    assign sync_o  = sync_q;
    assign z_re_o  = z_re_q;
    assign z_im_o  = z_im_q;

endmodule
